// File: rtl/multiplier_seq.sv
// multiplier_seq: sequential radix-2 shift-add multiplier.
// Captures operands on start, iterates one multiplier bit per clock for N
// clocks, then applies the sign and registers the 2N-bit product and flags.
module multiplier_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] R,
    output logic [N-1:0] R_hi,
    output logic         busy,
    output logic         done,
    output logic         N_flag,
    output logic         Z_flag,
    output logic         C_flag,
    output logic         V_flag
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplier;
    logic            neg;
    logic            sgn;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [2*N-1:0]  prod;
    logic [N-1:0]    prod_lo;
    logic [N-1:0]    prod_hi;

    // Operand magnitudes; the most-negative value maps to 2^(N-1), which
    // is still exact as an unsigned N-bit quantity.
    always_comb begin
        a_mag = (signed_mode && A[N-1]) ? (-A) : A;
        b_mag = (signed_mode && B[N-1]) ? (-B) : B;
    end

    // Signed final product from the unsigned accumulator.
    always_comb begin
        prod    = neg ? (-acc) : acc;
        prod_lo = prod[N-1:0];
        prod_hi = prod[2*N-1:N];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic and busy indication.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iterations, result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            sgn    <= 1'b0;
            R      <= '0;
            R_hi   <= '0;
            done   <= 1'b0;
            N_flag <= 1'b0;
            Z_flag <= 1'b0;
            C_flag <= 1'b0;
            V_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{N{1'b0}}, a_mag};
                        mplier <= b_mag;
                        sgn    <= signed_mode;
                        neg    <= signed_mode & (A[N-1] ^ B[N-1]);
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                FINISH: begin
                    R      <= prod_lo;
                    R_hi   <= prod_hi;
                    N_flag <= prod_lo[N-1];
                    Z_flag <= (prod_lo == '0);
                    C_flag <= ~sgn & (prod_hi != '0);
                    V_flag <= sgn & (prod_hi != {N{prod_lo[N-1]}});
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb_multiplier_seq: directed self-checking bench for multiplier_seq (N=32).
module tb_multiplier_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] R;
    logic [N-1:0] R_hi;
    logic         busy;
    logic         done;
    logic         N_flag;
    logic         Z_flag;
    logic         C_flag;
    logic         V_flag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiplier_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .A          (A),
        .B          (B),
        .R          (R),
        .R_hi       (R_hi),
        .busy       (busy),
        .done       (done),
        .N_flag     (N_flag),
        .Z_flag     (Z_flag),
        .C_flag     (C_flag),
        .V_flag     (V_flag)
    );

    // Present operands with start for one edge (edge 0); returns 1 time unit after it.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        @(negedge clk);
        A           = a;
        B           = b;
        signed_mode = s;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({R, R_hi} !== '0) begin
            failures++;
            $display("FAIL reset_result: got %h_%h expected 0", R_hi, R);
        end
        checks++;
        if ({busy, done, N_flag, Z_flag, C_flag, V_flag} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, N_flag, Z_flag, C_flag, V_flag});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_products();
        logic [N-1:0] ta [10] = '{32'h00010000, 32'h80000000, 32'h00000000, 32'h12345678,
                                  32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFE,
                                  32'h80000000, 32'h7FFFFFFF};
        logic [N-1:0] tb [10] = '{32'h00010000, 32'h00000002, 32'h00001234, 32'h00000010,
                                  32'h00000001, 32'h00000002, 32'hFFFFFFFB, 32'h00000003,
                                  32'h80000000, 32'h7FFFFFFF};
        logic         ts [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] elo [10] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h23456780,
                                   32'hFFFFFFFF, 32'h00000000, 32'h0000000F, 32'hFFFFFFFA,
                                   32'h00000000, 32'h00000001};
        logic [N-1:0] ehi [10] = '{32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
                                   32'h40000000, 32'h3FFFFFFF};
        // flags as {N, Z, C, V}
        logic [3:0]   efl [10] = '{4'b0110, 4'b0110, 4'b0100, 4'b0010,
                                   4'b1000, 4'b0101, 4'b0000, 4'b1000,
                                   4'b0101, 4'b0001};
        int e;
        for (int i = 0; i < 10; i++) begin
            launch(ta[i], tb[i], ts[i]);
            wait_done(e);
            checks++;
            if (e !== 33) begin
                failures++;
                $display("FAIL latency[%0d]: got %0d expected 33", i, e);
            end
            checks++;
            if (R !== elo[i]) begin
                failures++;
                $display("FAIL R[%0d]: got %h expected %h", i, R, elo[i]);
            end
            checks++;
            if (R_hi !== ehi[i]) begin
                failures++;
                $display("FAIL R_hi[%0d]: got %h expected %h", i, R_hi, ehi[i]);
            end
            checks++;
            if ({N_flag, Z_flag, C_flag, V_flag} !== efl[i]) begin
                failures++;
                $display("FAIL flags[%0d]: got %b expected %b", i,
                         {N_flag, Z_flag, C_flag, V_flag}, efl[i]);
            end
        end
    endtask

    task automatic test_busy();
        int low;
        launch(32'd5, 32'd6, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_start: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        low = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) low++;
        end
        checks++;
        if (low !== 0) begin
            failures++;
            $display("FAIL busy_hold: got %0d bad cycles expected 0", low);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || R !== 32'd30) begin
            failures++;
            $display("FAIL done_edge33: got busy=%b done=%b R=%h expected busy=0 done=1 R=1e",
                     busy, done, R);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || R !== 32'd30 || R_hi !== '0) begin
            failures++;
            $display("FAIL idle_hold: got done=%b busy=%b R=%h R_hi=%h expected 0 0 1e 0",
                     done, busy, R, R_hi);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done(e);
        checks++;
        if (e !== 33 || R !== 32'h00000001 || R_hi !== 32'hFFFFFFFE || C_flag !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: got e=%0d R=%h R_hi=%h C=%b expected 33 1 fffffffe 1",
                     e, R, R_hi, C_flag);
        end
        // start asserted in the done cycle itself
        A           = 32'd3;
        B           = 32'd5;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done(e);
        checks++;
        if (e !== 33 || R !== 32'd15 || R_hi !== '0) begin
            failures++;
            $display("FAIL b2b_second: got e=%0d R=%h R_hi=%h expected 33 f 0", e, R, R_hi);
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        int first;
        logic [N-1:0] r_seen;
        logic [N-1:0] rh_seen;
        pulses  = 0;
        first   = 0;
        r_seen  = '0;
        rh_seen = '1;
        launch(32'd7, 32'd9, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        A           = 32'h55;
        B           = 32'h66;
        signed_mode = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 11; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first   = k;
                    r_seen  = R;
                    rh_seen = R_hi;
                end
            end
        end
        checks++;
        if (pulses !== 1 || first !== 33) begin
            failures++;
            $display("FAIL ignore_done: got pulses=%0d at=%0d expected 1 at 33", pulses, first);
        end
        checks++;
        if (r_seen !== 32'd63 || rh_seen !== '0) begin
            failures++;
            $display("FAIL ignore_result: got %h_%h expected 0_3f", rh_seen, r_seen);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int e;
        launch(32'h1234, 32'h10, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({R, R_hi} !== '0 || {busy, done, N_flag, Z_flag, C_flag, V_flag} !== 6'b0) begin
            failures++;
            $display("FAIL abort_clear: got R=%h R_hi=%h ctrl=%b expected all 0", R, R_hi,
                     {busy, done, N_flag, Z_flag, C_flag, V_flag});
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort_nodone: got %0d active cycles expected 0", pulses);
        end
        launch(32'h1234, 32'h10, 1'b0);
        wait_done(e);
        checks++;
        if (e !== 33 || R !== 32'h12340 || R_hi !== '0 || Z_flag !== 1'b0) begin
            failures++;
            $display("FAIL abort_recover: got e=%0d R=%h R_hi=%h Z=%b expected 33 12340 0 0",
                     e, R, R_hi, Z_flag);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_busy();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
